// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/response bundle between a producer/consumer and bin2bcd_seq.
interface bin2bcd_seq_if
   import bin2bcd_pkg::*;
#(
   parameter int IN_W   = 18,
   parameter int DIGITS = 8
);

   logic                          in_valid;
   logic                          in_ready;
   logic [IN_W-1:0]               bin_in;
   logic                          signed_en;
   logic                          out_valid;
   logic                          out_ready;
   logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
   logic                          neg;
   logic                          ovf;

   modport master (
      output in_valid, bin_in, signed_en, out_ready,
      input  in_ready, out_valid, bcd_out, neg, ovf
   );

   modport slave (
      input  in_valid, bin_in, signed_en, out_ready,
      output in_ready, out_valid, bcd_out, neg, ovf
   );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// One double-dabble correction cell: a digit of 5 or more gets 3 added before the shift.
module bcd_add3
   import bin2bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] adjusted
);

   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, signed or unsigned input,
// sticky overflow when the magnitude does not fit in DIGITS decimal digits.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int IN_W   = 18,
   parameter int DIGITS = 8
)(
   input  logic         CLOCK_50,
   input  logic         rst_n,
   bin2bcd_seq_if.slave bus
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(IN_W + 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [IN_W-1:0]  mag_q;
   logic [BCD_W-1:0] work_bcd_q;
   logic             work_neg_q;
   logic             work_ovf_q;
   logic [BCD_W-1:0] bcd_q;
   logic             neg_q;
   logic             ovf_q;

   logic             in_ready_c;
   logic             out_valid_c;
   logic             accept;
   logic             last_shift;
   logic             neg_in;
   logic [IN_W-1:0]  mag_in;
   logic [BCD_W-1:0] bcd_adj;
   logic [BCD_W-1:0] bcd_shift;
   logic             ovf_next;

   // Negating the most negative input still fits as an IN_W-bit unsigned magnitude.
   assign neg_in = bus.signed_en & bus.bin_in[IN_W-1];
   assign mag_in = neg_in ? (~bus.bin_in + IN_W'(1)) : bus.bin_in;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_add3 u_add3 (
            .digit    (work_bcd_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end
   endgenerate

   assign bcd_shift  = {bcd_adj[BCD_W-2:0], mag_q[IN_W-1]};
   assign ovf_next   = work_ovf_q | bcd_adj[BCD_W-1];
   assign accept     = in_ready_c & bus.in_valid;
   assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(IN_W - 1));

   // State register.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)        state_d = SHIFT;
         SHIFT:   if (last_shift)    state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Handshake outputs depend on the state alone.
   always_comb begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE:    in_ready_c  = 1'b1;
         DONE:    out_valid_c = 1'b1;
         default: ;
      endcase
   end

   // Working registers shift while busy; the visible result only updates on DONE entry.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         mag_q      <= '0;
         work_bcd_q <= '0;
         work_neg_q <= 1'b0;
         work_ovf_q <= 1'b0;
         bcd_q      <= '0;
         neg_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (accept) begin
         cnt_q      <= '0;
         mag_q      <= mag_in;
         work_bcd_q <= '0;
         work_neg_q <= neg_in;
         work_ovf_q <= 1'b0;
      end else if (state_q == SHIFT) begin
         cnt_q      <= cnt_q + CNT_W'(1);
         mag_q      <= {mag_q[IN_W-2:0], 1'b0};
         work_bcd_q <= bcd_shift;
         work_ovf_q <= ovf_next;
         if (last_shift) begin
            bcd_q <= bcd_shift;
            neg_q <= work_neg_q;
            ovf_q <= ovf_next;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.bcd_out   = bcd_q;
   assign bus.neg       = neg_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised bench for bin2bcd_seq: an 8-digit and a 4-digit instance checked
// against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [31:0] prev_bcd [2];

   bin2bcd_seq_if #(.IN_W(18), .DIGITS(8)) bus_a ();
   bin2bcd_seq_if #(.IN_W(18), .DIGITS(4)) bus_b ();

   bin2bcd_seq #(.IN_W(18), .DIGITS(8)) dut_a (
      .CLOCK_50 (clk),
      .rst_n    (rst_n),
      .bus      (bus_a)
   );

   bin2bcd_seq #(.IN_W(18), .DIGITS(4)) dut_b (
      .CLOCK_50 (clk),
      .rst_n    (rst_n),
      .bus      (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so a stuck handshake cannot hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic valid, input logic [17:0] bin,
                                input logic sgn, input logic ordy);
      if (sel == 0) begin
         bus_a.in_valid  = valid;
         bus_a.bin_in    = bin;
         bus_a.signed_en = sgn;
         bus_a.out_ready = ordy;
      end else begin
         bus_b.in_valid  = valid;
         bus_b.bin_in    = bin;
         bus_b.signed_en = sgn;
         bus_b.out_ready = ordy;
      end
   endtask

   function automatic logic [31:0] getBcd(input int sel);
      return (sel == 0) ? bus_a.bcd_out : {16'h0, bus_b.bcd_out};
   endfunction

   // {in_ready, out_valid, neg, ovf}
   function automatic logic [3:0] getFlags(input int sel);
      return (sel == 0) ? {bus_a.in_ready, bus_a.out_valid, bus_a.neg, bus_a.ovf}
                        : {bus_b.in_ready, bus_b.out_valid, bus_b.neg, bus_b.ovf};
   endfunction

   // Reference: magnitude via integer arithmetic, digits via repeated division by ten.
   task automatic refConvert(input logic [17:0] v, input logic sgn, input int digits,
                             output logic [31:0] bcd, output logic neg, output logic ovf);
      longint mag;
      longint limit;
      longint m;
      neg   = sgn && v[17];
      mag   = neg ? (longint'(1) << 18) - longint'(v) : longint'(v);
      limit = 1;
      for (int i = 0; i < digits; i++) limit = limit * 10;
      ovf = (mag >= limit);
      bcd = '0;
      m   = mag;
      for (int i = 0; i < digits; i++) begin
         bcd[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
   endtask

   task automatic runConversion(input int sel, input logic [17:0] v, input logic sgn, input int hold);
      logic [31:0] exp_bcd;
      logic        exp_neg;
      logic        exp_ovf;
      logic [3:0]  f;
      int          lat;
      refConvert(v, sgn, (sel == 0) ? 8 : 4, exp_bcd, exp_neg, exp_ovf);
      @(posedge clk); #1;
      f = getFlags(sel);
      checkOutput("in_ready_idle", 64'(f[3]), 64'd1);
      applyStimulus(sel, 1'b1, v, sgn, 1'b0);
      @(posedge clk); #1;
      applyStimulus(sel, 1'b0, 18'($urandom), 1'($urandom), 1'b0);
      checkOutput("hold_prev", 64'(getBcd(sel)), 64'(prev_bcd[sel]));
      lat = 0;
      f   = getFlags(sel);
      while (!f[2] && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         f = getFlags(sel);
      end
      checkOutput("latency", 64'(lat), 64'd18);
      checkOutput("bcd", 64'(getBcd(sel)), 64'(exp_bcd));
      checkOutput("flags", 64'(f), 64'({1'b0, 1'b1, exp_neg, exp_ovf}));
      for (int k = 0; k < hold; k++) begin
         applyStimulus(sel, 1'($urandom), 18'($urandom), 1'($urandom), 1'b0);
         @(posedge clk); #1;
         checkOutput("stall_bcd", 64'(getBcd(sel)), 64'(exp_bcd));
         checkOutput("stall_flags", 64'(getFlags(sel)), 64'({1'b0, 1'b1, exp_neg, exp_ovf}));
      end
      applyStimulus(sel, 1'b0, 18'($urandom), 1'($urandom), 1'b1);
      @(posedge clk); #1;
      applyStimulus(sel, 1'b0, 18'($urandom), 1'($urandom), 1'b0);
      f = getFlags(sel);
      checkOutput("release_hs", 64'(f[3:2]), 64'(2'b10));
      checkOutput("release_bcd", 64'(getBcd(sel)), 64'(exp_bcd));
      prev_bcd[sel] = exp_bcd;
   endtask

   initial begin
      logic [17:0] dir_val [7];
      logic        dir_sgn [7];
      logic [3:0]  f;
      logic        seen;
      total = 0;
      bad   = 0;
      prev_bcd[0] = '0;
      prev_bcd[1] = '0;
      rst_n = 1'b0;
      applyStimulus(0, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, '0, 1'b0, 1'b0);
      #12;
      checkOutput("rst_flags_a", 64'(getFlags(0)), 64'(4'b1000));
      checkOutput("rst_bcd_a", 64'(getBcd(0)), 64'd0);
      checkOutput("rst_flags_b", 64'(getFlags(1)), 64'(4'b1000));
      @(negedge clk);
      rst_n = 1'b1;

      dir_val = '{18'h2D687, 18'd184135, 18'h00000, 18'h3FFFF, 18'h3FFFF, 18'h20000, 18'h1FFFF};
      dir_sgn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      runConversion(0, dir_val[0], dir_sgn[0], 10);
      for (int i = 1; i < 7; i++) runConversion(0, dir_val[i], dir_sgn[i], 1);

      runConversion(1, 18'd12345, 1'b0, 2);
      runConversion(1, 18'd9999, 1'b0, 2);
      runConversion(1, 18'd10000, 1'b0, 0);

      for (int i = 0; i < 20; i++)
         runConversion(0, 18'($urandom), 1'($urandom), $urandom_range(0, 3));
      for (int i = 0; i < 10; i++)
         runConversion(1, 18'($urandom_range(0, 20000)), 1'($urandom), $urandom_range(0, 2));

      // Abort a conversion seven shift cycles in.
      @(posedge clk); #1;
      applyStimulus(0, 1'b1, 18'h2D687, 1'b0, 1'b0);
      @(posedge clk); #1;
      applyStimulus(0, 1'b0, 18'h0, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      f = getFlags(0);
      checkOutput("abort_valid", 64'(f[2]), 64'd0);
      checkOutput("abort_bcd", 64'(getBcd(0)), 64'd0);
      checkOutput("abort_negovf", 64'(f[1:0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("abort_ready", 64'(getFlags(0)), 64'(4'b1000));
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         f = getFlags(0);
         if (f[2]) seen = 1'b1;
      end
      checkOutput("abort_no_valid", 64'(seen), 64'd0);
      prev_bcd[0] = '0;
      prev_bcd[1] = '0;
      runConversion(0, 18'h2D687, 1'b0, 0);
      runConversion(1, 18'd4321, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
